except_ctrl: RTL and testbench
==============================

// Module: except_ctrl
// PURPOSE
//  MEM-stage exception/interrupt controller; producer side of the CP0 exception interface.
//  - Prioritises per-instruction fault flags and pending interrupts, then issues one except_req to cp0.
//  - Drives the interrupt_flag bus into cp0.
//  - Flushes the pipeline, drains in-flight memory ops, then redirects fetch to the handler vector or ERET target.
// PARAMETERS
//  RESET_VEC_BEV   32'hBFC00380  handler vector when status.bev=1
//  RESET_VEC_NORM  32'h80000180  handler vector when status.bev=0
// PORTS
//  clk             in   1    clock
//  rst             in   1    asynchronous reset, active-high
//  mem_valid       in   1    valid instruction in MEM
//  mem_pc          in   32   PC of MEM instruction
//  mem_delayslot   in   1    MEM instruction is in a branch delay slot
//  mem_eret        in   1    MEM instruction is ERET
//  mem_exc         in   8    fault flags: [0]ADEL-fetch [1]TLBL-fetch [2]RI [3]CpU [4]Ov [5]Sys [6]Bp [7]data-fault
//  mem_cpu_ce      in   2    coprocessor number, used for CpU
//  mem_data_code   in   5    exc code of the data fault (ADEL/ADES/TLBL/TLBS/MOD)
//  mem_badvaddr    in   32   fault address: fetch PC or data VA
//  mem_busy        in   1    outstanding cache/uncached memory op
//  ext_int         in   6    raw external interrupt lines
//  timer_int       in   1    timer interrupt from cp0
//  cp0_regs        in   cp0_regs_t  architectural CP0 state
//  interrupt_flag  out  8    [7:2] to cp0 cause.ip; [1:0]=0
//  except_req      out  except_req_t  {valid, eret, code, pc, delayslot, extra} to cp0
//  flush           out  1    kill IF..MEM and hold stalls
//  redirect_valid  out  1    fetch redirect request
//  redirect_pc     out  32   redirect target
//  redirect_ready  in   1    fetch accepts redirect
// BEHAVIOUR
//  Reset: state=IDLE; except_req='0, flush=0, redirect_valid=0, redirect_pc=0, interrupt_flag=0.
//  interrupt_flag[7:2] = {ext_int_q[5] | timer_int, ext_int_q[4:0]}, where ext_int_q is the CONFIGURATION-selected source.
//  int_pend = status.ie & ~status.exl & ~status.erl & |(cause.ip & status.im).
//  Trigger: only in IDLE, with mem_valid=1, and (int_pend | |mem_exc | mem_eret).
//  Priority, highest first: INT(0), ADEL-fetch(4), TLBL-fetch(2), RI(10), CpU(11), Ov(12), Sys(8), Bp(9),
//  data-fault(mem_data_code), ERET.
//  except_req on the trigger cycle, combinational, exactly one cycle:
//   - valid=1, pc=mem_pc, delayslot=mem_delayslot.
//   - eret=1 only when ERET is the selected winner.
//   - extra = mem_badvaddr for address/TLB faults; {30'b0, mem_cpu_ce} for CpU; 0 otherwise.
//  redirect_pc is latched at trigger:
//   - ERET: status.erl ? error_epc : epc.
//   - Otherwise: status.bev ? RESET_VEC_BEV : RESET_VEC_NORM.
//  FSM:
//   - IDLE -trigger-> DRAIN; flush=1 from the trigger cycle.
//   - DRAIN: flush=1; -> REDIRECT when mem_busy=0. If mem_busy=0 on entry, DRAIN lasts exactly 1 cycle.
//   - REDIRECT: flush=1, redirect_valid=1, redirect_pc stable until handshake; redirect_valid&redirect_ready -> IDLE.
//   - redirect_valid drops the cycle after the handshake; flush drops at the same time.
//  Minimum trigger-to-redirect latency: 2 cycles (trigger, DRAIN, REDIRECT).
//  Any trigger condition while not IDLE is ignored; except_req.valid stays 0.
//  Interrupt and fault in the same cycle: interrupt wins; epc = mem_pc (instruction not committed).
//  Async reset mid-DRAIN/REDIRECT: immediate return to IDLE; all outputs go to reset values.
// CONFIGURATION
//  EXC_INT_SYNC_EN defined: ext_int_q comes from a 2-flop synchroniser on ext_int (reset 0); 2-cycle latency to interrupt_flag.
//  EXC_INT_SYNC_EN undefined: ext_int_q = ext_int, combinational; timer_int is never synchronised.
// TESTING
//  1 Sys at mem_pc=0x8000_1000, bev=0, mem_busy=0 -> except_req{valid,code=8,pc=0x80001000} 1 cycle;
//    redirect_valid 2 cycles later with redirect_pc=0x80000180.
//  2 Delay-slot ADES at mem_pc=0x8000_2004, va=0x1003 -> code=5, delayslot=1, extra=0x1003; mem_busy=1 for 4 cycles
//    -> DRAIN held 4 cycles, then redirect.
//  3 ie=1, im[2]=1, ext_int[0]=1 together with RI -> code=0 (interrupt wins); with EXC_INT_SYNC_EN,
//    interrupt_flag[2] rises 2 cycles after ext_int.
//  4 ERET with erl=0, epc=0x8000_3000 -> except_req.eret=1; redirect_pc=0x80003000.
//  5 redirect_ready held 0 for 5 cycles -> redirect_valid/pc stable; second fault during wait -> no except_req.
//  6 rst asserted in REDIRECT -> flush=0, redirect_valid=0 immediately; a fault after reset is accepted normally.

Source files
------------

// File: rtl/except_ctrl_if.sv
// except_ctrl_if: MEM-stage exception controller bundle.
// Carries the MEM instruction, memory-busy, interrupt inputs, CP0 state,
// the except_req record to cp0 and the fetch redirect handshake.
// master = except_ctrl (producer), slave = pipeline/cp0 side.
interface except_ctrl_if;

  typedef struct packed {
    logic       bev;
    logic [7:0] im;
    logic       erl;
    logic       exl;
    logic       ie;
  } status_t;

  typedef struct packed {
    status_t     status;
    logic [7:0]  cause_ip;
    logic [31:0] epc;
    logic [31:0] error_epc;
  } cp0_regs_t;

  typedef struct packed {
    logic        valid;
    logic        eret;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        delayslot;
    logic [31:0] extra;
  } except_req_t;

  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_delayslot;
  logic        mem_eret;
  logic [7:0]  mem_exc;
  logic [1:0]  mem_cpu_ce;
  logic [4:0]  mem_data_code;
  logic [31:0] mem_badvaddr;
  logic        mem_busy;
  logic [5:0]  ext_int;
  logic        timer_int;
  cp0_regs_t   cp0_regs;
  logic [7:0]  interrupt_flag;
  except_req_t except_req;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    input  mem_valid, mem_pc, mem_delayslot, mem_eret, mem_exc, mem_cpu_ce,
           mem_data_code, mem_badvaddr, mem_busy, ext_int, timer_int,
           cp0_regs, redirect_ready,
    output interrupt_flag, except_req, flush, redirect_valid, redirect_pc
  );

  modport slave (
    output mem_valid, mem_pc, mem_delayslot, mem_eret, mem_exc, mem_cpu_ce,
           mem_data_code, mem_badvaddr, mem_busy, ext_int, timer_int,
           cp0_regs, redirect_ready,
    input  interrupt_flag, except_req, flush, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/except_ctrl.sv
// except_ctrl: MEM-stage exception/interrupt controller.
// Picks the highest-priority interrupt/fault/ERET of the MEM instruction,
// issues a one-cycle except_req to cp0, flushes the pipeline, waits for
// outstanding memory ops to drain, then redirects fetch to the handler
// vector or the ERET return address.
// Optional build macro EXC_INT_SYNC_EN: passes ext_int through a 2-flop
// synchroniser before it reaches interrupt_flag (timer_int stays direct).
module except_ctrl #(
  parameter logic [31:0] RESET_VEC_BEV  = 32'hBFC00380,
  parameter logic [31:0] RESET_VEC_NORM = 32'h80000180
) (
  input logic         clk,
  input logic         rst,
  except_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} state_t;

  state_t      state;
  state_t      next_state;
  logic [5:0]  ext_int_q;
  logic        int_pend;
  logic        trigger;
  logic [4:0]  code;
  logic        sel_eret;
  logic [31:0] extra;
  logic [31:0] target;
  logic [31:0] redirect_pc_q;

`ifdef EXC_INT_SYNC_EN
  logic [5:0] ext_sync1;
  logic [5:0] ext_sync2;

  // Two-flop synchroniser for the asynchronous external interrupt lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_sync1 <= '0;
      ext_sync2 <= '0;
    end else begin
      ext_sync1 <= bus.ext_int;
      ext_sync2 <= ext_sync1;
    end
  end

  assign ext_int_q = ext_sync2;
`else
  assign ext_int_q = bus.ext_int;
`endif

  assign bus.interrupt_flag = rst ? 8'h00
                                  : {ext_int_q[5] | bus.timer_int, ext_int_q[4:0], 2'b00};

  assign int_pend = bus.cp0_regs.status.ie & ~bus.cp0_regs.status.exl &
                    ~bus.cp0_regs.status.erl &
                    (|(bus.cp0_regs.cause_ip & bus.cp0_regs.status.im));

  assign trigger = ~rst && (state == IDLE) && bus.mem_valid &&
                   (int_pend || (|bus.mem_exc) || bus.mem_eret);

  // Priority encoder: interrupt first, then fetch faults, decode faults,
  // execute faults, data fault and finally ERET.
  always_comb begin
    code     = 5'd0;
    sel_eret = 1'b0;
    extra    = 32'h0;
    if (int_pend) begin
      code = 5'd0;
    end else if (bus.mem_exc[0]) begin
      code  = 5'd4;
      extra = bus.mem_badvaddr;
    end else if (bus.mem_exc[1]) begin
      code  = 5'd2;
      extra = bus.mem_badvaddr;
    end else if (bus.mem_exc[2]) begin
      code = 5'd10;
    end else if (bus.mem_exc[3]) begin
      code  = 5'd11;
      extra = {30'b0, bus.mem_cpu_ce};
    end else if (bus.mem_exc[4]) begin
      code = 5'd12;
    end else if (bus.mem_exc[5]) begin
      code = 5'd8;
    end else if (bus.mem_exc[6]) begin
      code = 5'd9;
    end else if (bus.mem_exc[7]) begin
      code  = bus.mem_data_code;
      extra = bus.mem_badvaddr;
    end else if (bus.mem_eret) begin
      sel_eret = 1'b1;
    end
  end

  // Redirect target: ERET return address or the exception handler vector.
  always_comb begin
    target = bus.cp0_regs.status.bev ? RESET_VEC_BEV : RESET_VEC_NORM;
    if (sel_eret) begin
      target = bus.cp0_regs.status.erl ? bus.cp0_regs.error_epc : bus.cp0_regs.epc;
    end
  end

  // One-cycle exception record towards cp0, only on the trigger cycle.
  always_comb begin
    bus.except_req = '0;
    if (trigger) begin
      bus.except_req.valid     = 1'b1;
      bus.except_req.eret      = sel_eret;
      bus.except_req.code      = code;
      bus.except_req.pc        = bus.mem_pc;
      bus.except_req.delayslot = bus.mem_delayslot;
      bus.except_req.extra     = extra;
    end
  end

  // State register plus the redirect target captured at the trigger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      redirect_pc_q <= 32'h0;
    end else begin
      state <= next_state;
      if (trigger) begin
        redirect_pc_q <= target;
      end
    end
  end

  // Next-state logic: flush, drain memory, then hold redirect until accepted.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (trigger) next_state = DRAIN;
      DRAIN:    if (!bus.mem_busy) next_state = REDIRECT;
      REDIRECT: if (bus.redirect_ready) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  assign bus.flush          = trigger || (state != IDLE);
  assign bus.redirect_valid = (state == REDIRECT);
  assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_except_ctrl.sv
// tb_except_ctrl: episode-based randomized bench for except_ctrl.
// Each episode presents one MEM instruction in IDLE, then walks the
// expected flush / drain / redirect timeline, injecting ignored faults
// while busy. Expected values come from a rule-level reference model.
module tb_except_ctrl;

  localparam logic [31:0] VEC_BEV  = 32'hBFC00380;
  localparam logic [31:0] VEC_NORM = 32'h80000180;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  except_ctrl_if bus();

  except_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stimulus record for one episode.
  logic [7:0]  s_exc;
  logic        s_eret;
  logic [31:0] s_pc;
  logic        s_ds;
  logic [1:0]  s_ce;
  logic [4:0]  s_dcode;
  logic [31:0] s_va;
  logic        s_bev, s_erl, s_exl, s_ie;
  logic [7:0]  s_im;
  logic [7:0]  s_cause_ip;
  logic [31:0] s_epc, s_eepc;
  logic [5:0]  s_ext;
  logic        s_timer;
  int          s_busy_n;
  int          s_wait_n;
  logic        s_rst_mid;

  // Expected results from the reference model.
  logic        exp_trig;
  logic [71:0] exp_req;
  logic [31:0] exp_target;

  // ext_int history: previous cycle and two cycles back.
  logic [5:0] h1, h2;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: rules of prioritisation written as a table scan.
  task automatic model_compute();
    int          codes[8];
    int          winner;
    logic        int_pend;
    logic        eret_win;
    logic [4:0]  code;
    logic [31:0] extra;
    codes = '{4, 2, 10, 11, 12, 8, 9, int'(s_dcode)};
    int_pend = s_ie && !s_exl && !s_erl && ((s_cause_ip & s_im) != 8'h00);
    winner = -1;
    for (int i = 0; i < 8; i++) begin
      if (s_exc[i] && winner < 0) winner = i;
    end
    exp_trig   = int_pend || (s_exc != 8'h00) || s_eret;
    eret_win   = 1'b0;
    code       = 5'd0;
    extra      = 32'h0;
    exp_target = s_bev ? VEC_BEV : VEC_NORM;
    if (int_pend) begin
      code = 5'd0;
    end else if (winner >= 0) begin
      code = 5'(codes[winner]);
      if (winner == 0 || winner == 1 || winner == 7) extra = s_va;
      else if (winner == 3) extra = {30'b0, s_ce};
    end else if (s_eret) begin
      eret_win   = 1'b1;
      exp_target = s_erl ? s_eepc : s_epc;
    end
    exp_req = exp_trig ? {1'b1, eret_win, code, s_pc, s_ds, extra} : 72'h0;
  endtask

  task automatic cycle_start();
    @(posedge clk);
    #1;
    h2 = h1;
    h1 = bus.ext_int;
  endtask

  task automatic check_flag();
    logic [5:0] e;
`ifdef EXC_INT_SYNC_EN
    e = h2;
`else
    e = bus.ext_int;
`endif
    checkOutput("interrupt_flag", bus.interrupt_flag, {e[5] | bus.timer_int, e[4:0], 2'b00});
  endtask

  task automatic drive_episode();
    bus.mem_valid              = 1'b1;
    bus.mem_pc                 = s_pc;
    bus.mem_delayslot          = s_ds;
    bus.mem_eret               = s_eret;
    bus.mem_exc                = s_exc;
    bus.mem_cpu_ce             = s_ce;
    bus.mem_data_code          = s_dcode;
    bus.mem_badvaddr           = s_va;
    bus.ext_int                = s_ext;
    bus.timer_int              = s_timer;
    bus.cp0_regs.status.bev    = s_bev;
    bus.cp0_regs.status.im     = s_im;
    bus.cp0_regs.status.erl    = s_erl;
    bus.cp0_regs.status.exl    = s_exl;
    bus.cp0_regs.status.ie     = s_ie;
    bus.cp0_regs.cause_ip      = s_cause_ip;
    bus.cp0_regs.epc           = s_epc;
    bus.cp0_regs.error_epc     = s_eepc;
  endtask

  // Faults presented while busy must be ignored; CP0 state scrambled to
  // show the redirect target was captured at the trigger.
  task automatic drive_junk();
    bus.mem_valid          = 1'b1;
    bus.mem_exc            = 8'($urandom) | 8'h01;
    bus.mem_eret           = 1'($urandom);
    bus.mem_pc             = $urandom;
    bus.ext_int            = 6'($urandom);
    bus.cp0_regs.epc       = $urandom;
    bus.cp0_regs.error_epc = $urandom;
    bus.cp0_regs.status.bev = 1'($urandom);
  endtask

  task automatic set_defaults();
    s_exc = 8'h00; s_eret = 1'b0; s_pc = 32'h0; s_ds = 1'b0; s_ce = 2'd0;
    s_dcode = 5'd0; s_va = 32'h0; s_bev = 1'b0; s_erl = 1'b0; s_exl = 1'b0;
    s_ie = 1'b0; s_im = 8'h00; s_cause_ip = 8'h00; s_epc = 32'h0; s_eepc = 32'h0;
    s_ext = 6'h00; s_timer = 1'b0; s_busy_n = 0; s_wait_n = 0; s_rst_mid = 1'b0;
  endtask

  // Run one episode and check every cycle of its timeline.
  task automatic applyStimulus();
    model_compute();
    cycle_start();
    drive_episode();
    bus.mem_busy       = (s_busy_n > 0);
    bus.redirect_ready = 1'b0;
    @(negedge clk);
    check_flag();
    checkOutput("except_req", bus.except_req, exp_req);
    checkOutput("flush_trig", bus.flush, exp_trig);
    checkOutput("rv_trig", bus.redirect_valid, 1'b0);
    if (!exp_trig) begin
      return;
    end
    for (int j = 0; j <= s_busy_n; j++) begin
      cycle_start();
      drive_junk();
      bus.mem_busy = (j < s_busy_n);
      @(negedge clk);
      check_flag();
      checkOutput("req_drain", bus.except_req, 72'h0);
      checkOutput("flush_drain", bus.flush, 1'b1);
      checkOutput("rv_drain", bus.redirect_valid, 1'b0);
    end
    for (int k = 0; k <= s_wait_n; k++) begin
      cycle_start();
      drive_junk();
      bus.mem_busy       = 1'($urandom);
      bus.redirect_ready = (k == s_wait_n);
      @(negedge clk);
      check_flag();
      checkOutput("rv_redir", bus.redirect_valid, 1'b1);
      checkOutput("rpc_redir", bus.redirect_pc, exp_target);
      checkOutput("flush_redir", bus.flush, 1'b1);
      checkOutput("req_redir", bus.except_req, 72'h0);
      if (s_rst_mid && k == 1) begin
        bus.ext_int   = 6'h00;
        bus.timer_int = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checkOutput("flush_rst", bus.flush, 1'b0);
        checkOutput("rv_rst", bus.redirect_valid, 1'b0);
        checkOutput("rpc_rst", bus.redirect_pc, 32'h0);
        checkOutput("req_rst", bus.except_req, 72'h0);
        checkOutput("iflag_rst", bus.interrupt_flag, 8'h00);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.mem_valid = 1'b0;
        h1 = 6'h00;
        h2 = 6'h00;
        return;
      end
    end
    cycle_start();
    bus.mem_valid      = 1'b0;
    bus.redirect_ready = 1'b0;
    bus.mem_busy       = 1'b0;
    @(negedge clk);
    check_flag();
    checkOutput("rv_after", bus.redirect_valid, 1'b0);
    checkOutput("flush_after", bus.flush, 1'b0);
    checkOutput("req_after", bus.except_req, 72'h0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized episodes.
  initial begin
    rst = 1'b1;
    h1 = 6'h00;
    h2 = 6'h00;
    set_defaults();
    drive_episode();
    bus.mem_valid      = 1'b0;
    bus.mem_busy       = 1'b0;
    bus.redirect_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_req", bus.except_req, 72'h0);
    checkOutput("reset_flush", bus.flush, 1'b0);
    checkOutput("reset_rv", bus.redirect_valid, 1'b0);
    checkOutput("reset_rpc", bus.redirect_pc, 32'h0);
    checkOutput("reset_iflag", bus.interrupt_flag, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Syscall to the normal vector, no memory stall.
    set_defaults();
    s_exc = 8'h20; s_pc = 32'h80001000;
    applyStimulus();

    // Delay-slot data store fault with a 4-cycle drain.
    set_defaults();
    s_exc = 8'h80; s_dcode = 5'd5; s_pc = 32'h80002004; s_ds = 1'b1;
    s_va = 32'h00001003; s_busy_n = 4;
    applyStimulus();

    // Interrupt beats a reserved-instruction fault.
    set_defaults();
    s_exc = 8'h04; s_ie = 1'b1; s_im = 8'h04; s_cause_ip = 8'h04; s_ext = 6'h01;
    s_pc = 32'h80004000; s_bev = 1'b1;
    applyStimulus();

    // ERET returns to epc.
    set_defaults();
    s_eret = 1'b1; s_epc = 32'h80003000; s_eepc = 32'hBFC01234; s_pc = 32'h80005000;
    applyStimulus();

    // Redirect held off for 5 cycles.
    set_defaults();
    s_exc = 8'h08; s_ce = 2'd2; s_pc = 32'h80006000; s_wait_n = 5;
    applyStimulus();

    // Reset in REDIRECT, then a normal fault afterwards.
    set_defaults();
    s_exc = 8'h10; s_pc = 32'h80007000; s_wait_n = 3; s_rst_mid = 1'b1;
    applyStimulus();
    set_defaults();
    s_exc = 8'h01; s_va = 32'h80007001; s_pc = 32'h80007001; s_bev = 1'b1;
    applyStimulus();

    for (int n = 0; n < 60; n++) begin
      set_defaults();
      s_exc      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom) & 8'(1 << $urandom_range(0, 7) | $urandom);
      s_eret     = 1'($urandom);
      s_pc       = $urandom;
      s_ds       = 1'($urandom);
      s_ce       = 2'($urandom);
      s_dcode    = 5'($urandom_range(1, 7));
      s_va       = $urandom;
      s_bev      = 1'($urandom);
      s_erl      = ($urandom_range(0, 3) == 0);
      s_exl      = ($urandom_range(0, 3) == 0);
      s_ie       = 1'($urandom);
      s_im       = 8'($urandom);
      s_cause_ip = 8'($urandom) & 8'($urandom);
      s_epc      = $urandom;
      s_eepc     = $urandom;
      s_ext      = 6'($urandom);
      s_timer    = 1'($urandom);
      s_busy_n   = $urandom_range(0, 3);
      s_wait_n   = $urandom_range(0, 3);
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
